// File: rtl/step_sequencer_pkg.sv
// Shared types and helpers for the step sequencer.
// Optional feature macro: SEQ_SWING_EN (swing timing in step_len).
package synth_seq_pkg;

    localparam int FREQ_BITS       = 4;
    localparam int STEP_BASE_TICKS = 64;
    localparam int LEN_W           = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                 note_on;
        logic [FREQ_BITS-1:0] note;
    } seq_entry_t;

    // Step length in ticks: base scaled by tempo, optionally swung by step parity.
    function automatic logic [LEN_W-1:0] step_len(input logic [LEN_W-1:0] base,
                                                  input logic [1:0]       tempo,
                                                  input logic             odd);
        logic [LEN_W-1:0] p;
        p = base << tempo;
`ifdef SEQ_SWING_EN
        if (odd) return p - (p >> 2);
        else     return p + (p >> 2);
`else
        begin
            logic unused_odd;
            unused_odd = odd;
        end
        return p;
`endif
    endfunction

endpackage

// File: rtl/step_sequencer_tick_prescaler.sv
// Tempo prescaler: one-clk tick every TICK_DIV clocks, held at zero by clear.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at TICK_DIV-1, forced to zero while cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)                          cnt_d = '0;
        else if (cnt_q == CW'(TICK_DIV - 1)) cnt_d = '0;
        else                                cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = !clear && (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: plays a writable note pattern, driving tone_freq_bin and the
// hold gate of soundproc. Hold is high for the first half of each note step.
// Optional feature macro: SEQ_SWING_EN (even steps long, odd steps short).
// Handshake: none; wr_en is a single-cycle write strobe, always accepted.
module step_sequencer
    import synth_seq_pkg::*;
#(
    parameter int STEPS           = 8,
    parameter int FREQ_BITS       = synth_seq_pkg::FREQ_BITS,
    parameter int TICK_DIV        = 50000,
    parameter int STEP_BASE_TICKS = synth_seq_pkg::STEP_BASE_TICKS,
    localparam int SW             = $clog2(STEPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [1:0]           tempo,
    input  logic [SW-1:0]        last_step,
    input  logic                 wr_en,
    input  logic [SW-1:0]        wr_addr,
    input  logic [FREQ_BITS:0]   wr_data,
    output logic [FREQ_BITS-1:0] tone_freq_bin,
    output logic                 hold,
    output logic [SW-1:0]        step_idx,
    output logic                 step_strobe,
    output seq_state_t           state_dbg_o
);

    seq_state_t           state_q, state_d;
    logic [SW-1:0]        step_idx_q, step_idx_d;
    logic [LEN_W-1:0]     step_cnt_q, step_cnt_d;
    logic [1:0]           tempo_l_q, tempo_l_d;
    logic [FREQ_BITS-1:0] tone_q, tone_d;
    logic                 hold_q, hold_d;
    logic                 strobe_q, strobe_d;
    seq_entry_t           pattern_q [STEPS];

    logic                 tick;
    logic                 presc_clear;
    logic [LEN_W-1:0]     len, half;
    logic [SW-1:0]        next_idx, start_idx;
    logic                 do_start;
    seq_entry_t           start_entry;

    assign presc_clear = (state_q == IDLE) || !run;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .tick  (tick)
    );

    assign len         = step_len(LEN_W'(STEP_BASE_TICKS), tempo_l_q, step_idx_q[0]);
    assign half        = len >> 1;
    assign next_idx    = (step_idx_q >= last_step) ? '0 : step_idx_q + SW'(1);
    assign start_idx   = (state_q == IDLE) ? '0 : next_idx;
    // Read before this clk's write commits, so a colliding write is not seen.
    assign start_entry = pattern_q[start_idx];

    // Next-state and output logic of the step FSM.
    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        step_cnt_d = step_cnt_q;
        tempo_l_d  = tempo_l_q;
        tone_d     = tone_q;
        hold_d     = hold_q;
        strobe_d   = 1'b0;
        do_start   = 1'b0;
        if (!run) begin
            state_d    = IDLE;
            step_idx_d = '0;
            step_cnt_d = '0;
            hold_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: do_start = 1'b1;
                GATE: if (tick) begin
                    step_cnt_d = step_cnt_q + LEN_W'(1);
                    if (step_cnt_q == half - LEN_W'(1)) begin
                        state_d = GAP;
                        hold_d  = 1'b0;
                    end
                end
                GAP: if (tick) begin
                    if (step_cnt_q == len - LEN_W'(1)) do_start = 1'b1;
                    else step_cnt_d = step_cnt_q + LEN_W'(1);
                end
                default: state_d = IDLE;
            endcase
            if (do_start) begin
                state_d    = GATE;
                step_idx_d = start_idx;
                step_cnt_d = '0;
                tempo_l_d  = tempo;
                strobe_d   = 1'b1;
                hold_d     = start_entry.note_on;
                // Rests leave the previous note code on the output.
                if (start_entry.note_on) tone_d = start_entry.note;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
            step_cnt_q <= '0;
            tempo_l_q  <= '0;
            tone_q     <= '0;
            hold_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            step_cnt_q <= step_cnt_d;
            tempo_l_q  <= tempo_l_d;
            tone_q     <= tone_d;
            hold_q     <= hold_d;
            strobe_q   <= strobe_d;
        end
    end

    // Pattern memory: synchronous writes, cleared to rests on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) pattern_q[i] <= '0;
        end else if (wr_en) begin
            pattern_q[wr_addr] <= seq_entry_t'(wr_data);
        end
    end

    assign tone_freq_bin = tone_q;
    assign hold          = hold_q;
    assign step_idx      = step_idx_q;
    assign step_strobe   = strobe_q;
    assign state_dbg_o   = state_q;

endmodule
